mod_exp_engine: RTL and testbench

Parametrised sequential modular exponentiation engine, result = base^expo mod N, and the next generation of the RSA datapath core. It uses left-to-right square-and-multiply over a bit-serial interleaved modular multiplier, so there is no wide DSP product or lookup ROM, and N width scales freely. It adds a start/ready/valid handshake, input base reduction, an error flag for N==0 and an optional constant-time mode. It sits under the RSA top level as its arithmetic core.

---
 rtl/mod_exp_pkg.sv | 22 ++
 rtl/mod_mult_serial.sv | 88 ++++++++
 rtl/mod_exp_engine.sv | 167 ++++++++++++++++
 tb/tb_mod_exp_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// -----------------------------------------------------------------------------
// mod_exp_pkg
// Shared definitions for the modular exponentiation engine.
//   state_t / IDLE..DONE : FSM state encoding used by mod_exp_engine
//   mult_cycles()        : cycles taken by one serial modular multiply
//                          (one load cycle plus one cycle per multiplier bit)
// -----------------------------------------------------------------------------
package mod_exp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t REDUCE = 3'd1;
    localparam state_t SQUARE = 3'd2;
    localparam state_t MULT   = 3'd3;
    localparam state_t DONE   = 3'd4;

    function automatic int mult_cycles(input int n_w);
        return n_w + 1;
    endfunction

endpackage

// File: rtl/mod_mult_serial.sv
// -----------------------------------------------------------------------------
// mod_mult_serial
// Bit-serial interleaved modular multiplier: p = a*b mod N.
// Takes mult_cycles(N_W) cycles: the cycle in which go is seen loads the
// operands, then one cycle per bit of b, MSB first. Requires a, b < N.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   go         start a multiply (ignored while busy)
//   a, b, N    operands and modulus, captured on go
//   busy       multiply in progress
//   done       final iteration cycle; p is valid in this cycle only
//   p          product modulo N
// -----------------------------------------------------------------------------
module mod_mult_serial
    import mod_exp_pkg::*;
#(
    parameter int N_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [N_W-1:0] a,
    input  logic [N_W-1:0] b,
    input  logic [N_W-1:0] N,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] p
);

    localparam int MULT_CYCLES = mult_cycles(N_W);
    localparam int ITERS       = MULT_CYCLES - 1;
    localparam int CW          = $clog2(ITERS + 1);

    logic [N_W+1:0] r;
    logic [N_W-1:0] a_q;
    logic [N_W-1:0] b_q;
    logic [N_W-1:0] n_q;
    logic [CW-1:0]  cnt;

    logic [N_W+1:0] dbl;
    logic [N_W+1:0] dbl_m;
    logic [N_W+1:0] sum;
    logic [N_W+1:0] r_next;

    // One interleaved step. r < N on entry, so 2r and (r mod N)+a both stay
    // below 2N and a single conditional subtract brings each back below N.
    // NOTE: every always_comb output is assigned on every path, so no latch.
    always_comb begin
        dbl    = r << 1;
        dbl_m  = (dbl >= {2'b00, n_q}) ? dbl - {2'b00, n_q} : dbl;
        sum    = dbl_m + (b_q[N_W-1] ? {2'b00, a_q} : '0);
        r_next = (sum >= {2'b00, n_q}) ? sum - {2'b00, n_q} : sum;
    end

    assign done = busy && (cnt == '0);
    assign p    = N_W'(r_next);

    // NOTE: state registers use non-blocking assignments and every one of
    // them is cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r    <= '0;
            a_q  <= '0;
            b_q  <= '0;
            n_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (!busy) begin
            if (go) begin
                r    <= '0;
                a_q  <= a;
                b_q  <= b;
                n_q  <= N;
                cnt  <= CW'(ITERS - 1);
                busy <= 1'b1;
            end
        end else begin
            r   <= r_next;
            b_q <= b_q << 1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// -----------------------------------------------------------------------------
// mod_exp_engine
// Sequential modular exponentiation, result = base^expo mod N, using
// left-to-right square-and-multiply over one shared mod_mult_serial.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            request, accepted only while ready=1
//   base, expo, N    operands, sampled on accept
//   ready            idle, able to accept start
//   result           base^expo mod N, held until the next accept
//   valid            one-cycle pulse when result is fresh
//   err              raised with valid when the sampled N was 0
// -----------------------------------------------------------------------------
module mod_exp_engine
    import mod_exp_pkg::*;
#(
    parameter int BASE_W     = 16,
    parameter int EXPO_W     = 16,
    parameter int N_W        = 16,
    parameter int CONST_TIME = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BASE_W-1:0] base,
    input  logic [EXPO_W-1:0] expo,
    input  logic [N_W-1:0]    N,
    output logic              ready,
    output logic [N_W-1:0]    result,
    output logic              valid,
    output logic              err
);

    localparam int BW = (BASE_W > 1) ? $clog2(BASE_W) : 1;
    localparam int EW = (EXPO_W > 1) ? $clog2(EXPO_W) : 1;

    state_t            state;
    logic [BASE_W-1:0] base_q;
    logic [EXPO_W-1:0] expo_q;
    logic [N_W-1:0]    n_q;
    logic [N_W-1:0]    acc;
    logic [N_W-1:0]    red_r;    // base mod N once REDUCE has finished
    logic [BW-1:0]     red_idx;
    logic [EW-1:0]     bit_idx;

    logic              mult_go;
    logic              mult_busy;
    logic              mult_done;
    logic [N_W-1:0]    mult_b;
    logic [N_W-1:0]    mult_p;

    logic [N_W:0]      red_dbl;
    logic [N_W:0]      red_next;
    logic              bit_set;

    // Same double / compare / subtract step as the multiplier, with the next
    // base bit shifted in where the multiplier adds a.
    always_comb begin
        red_dbl  = {red_r, base_q[red_idx]};
        red_next = (red_dbl >= {1'b0, n_q}) ? red_dbl - {1'b0, n_q} : red_dbl;
    end

    assign bit_set = expo_q[bit_idx];
    assign mult_go = ((state == SQUARE) || (state == MULT)) && !mult_busy;
    assign mult_b  = (state == MULT) ? red_r : acc;
    assign ready   = (state == IDLE);
    assign valid   = (state == DONE);

    mod_mult_serial #(.N_W(N_W)) u_mult (
        .clk  (clk),
        .rst  (rst),
        .go   (mult_go),
        .a    (acc),
        .b    (mult_b),
        .N    (n_q),
        .busy (mult_busy),
        .done (mult_done),
        .p    (mult_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            expo_q  <= '0;
            n_q     <= '0;
            acc     <= '0;
            red_r   <= '0;
            red_idx <= '0;
            bit_idx <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base;
                        expo_q  <= expo;
                        n_q     <= N;
                        red_r   <= '0;
                        red_idx <= BW'(BASE_W - 1);
                        bit_idx <= EW'(EXPO_W - 1);
                        result  <= '0;
                        // 1 mod 1 is 0, so the running product starts at 0.
                        acc     <= (N == N_W'(1)) ? '0 : N_W'(1);
                        if (N == '0) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= REDUCE;
                        end
                    end
                end

                REDUCE: begin
                    red_r <= N_W'(red_next);
                    if (red_idx == '0) begin
                        state <= SQUARE;
                    end else begin
                        red_idx <= red_idx - BW'(1);
                    end
                end

                SQUARE: begin
                    if (mult_done) begin
                        acc <= mult_p;
                        if ((CONST_TIME != 0) || bit_set) begin
                            state <= MULT;
                        end else if (bit_idx == '0) begin
                            result <= mult_p;
                            state  <= DONE;
                        end else begin
                            bit_idx <= bit_idx - EW'(1);
                        end
                    end
                end

                MULT: begin
                    // In constant-time mode the product for a 0 bit is
                    // computed and dropped so timing does not leak expo.
                    if (mult_done) begin
                        if (bit_set) begin
                            acc <= mult_p;
                        end
                        if (bit_idx == '0) begin
                            result <= bit_set ? mult_p : acc;
                            state  <= DONE;
                        end else begin
                            bit_idx <= bit_idx - EW'(1);
                            state   <= SQUARE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_engine
// Directed bench for mod_exp_engine: one constant-time instance and one
// variable-time instance sharing operand inputs, plus a small reference model
// for the random N=0xFFFD vectors.
// -----------------------------------------------------------------------------
module tb_mod_exp_engine;

    logic        clk = 1'b0;
    logic        rst_ct, rst_nc;
    logic        start_ct, start_nc;
    logic [15:0] base, expo, n_in;
    logic        ready_ct, valid_ct, err_ct;
    logic        ready_nc, valid_nc, err_nc;
    logic [15:0] result_ct, result_nc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_exp_engine #(.BASE_W(16), .EXPO_W(16), .N_W(16), .CONST_TIME(1)) dut_ct (
        .clk    (clk),
        .rst    (rst_ct),
        .start  (start_ct),
        .base   (base),
        .expo   (expo),
        .N      (n_in),
        .ready  (ready_ct),
        .result (result_ct),
        .valid  (valid_ct),
        .err    (err_ct)
    );

    mod_exp_engine #(.BASE_W(16), .EXPO_W(16), .N_W(16), .CONST_TIME(0)) dut_nc (
        .clk    (clk),
        .rst    (rst_nc),
        .start  (start_nc),
        .base   (base),
        .expo   (expo),
        .N      (n_in),
        .ready  (ready_nc),
        .result (result_nc),
        .valid  (valid_nc),
        .err    (err_nc)
    );

    function automatic logic rdy(input bit s);
        return s ? ready_nc : ready_ct;
    endfunction

    function automatic logic vld(input bit s);
        return s ? valid_nc : valid_ct;
    endfunction

    function automatic logic er(input bit s);
        return s ? err_nc : err_ct;
    endfunction

    function automatic logic [15:0] res(input bit s);
        return s ? result_nc : result_ct;
    endfunction

    // Right-to-left reference, independent of the engine's bit order.
    function automatic logic [15:0] ref_modexp(input logic [15:0] b,
                                               input logic [15:0] e,
                                               input logic [15:0] n);
        longint unsigned r, x, nn;
        nn = longint'(n);
        r  = 64'd1 % nn;
        x  = longint'(b) % nn;
        for (int k = 0; k < 16; k++) begin
            if (e[k]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return 16'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one request and returns #1 after the accept edge (cycle 1).
    task automatic issue(input bit s, input logic [15:0] b, input logic [15:0] e,
                         input logic [15:0] n, input bit hold);
        @(negedge clk);
        for (int k = 0; k < 2000 && !rdy(s); k++) @(negedge clk);
        base = b;
        expo = e;
        n_in = n;
        if (s) start_nc = 1'b1; else start_ct = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start_ct = 1'b0;
            start_nc = 1'b0;
        end
    endtask

    task automatic wait_valid(input bit s, output int lat);
        lat = 1;
        while (!vld(s) && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input bit s, input logic [15:0] b, input logic [15:0] e,
                       input logic [15:0] n, input logic [15:0] exp_res,
                       input logic exp_err, input int exp_lat, input string tag);
        int lat;
        issue(s, b, e, n, 1'b0);
        wait_valid(s, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, res(s), exp_res);
        check({tag, "_err"}, er(s), exp_err);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, vld(s), 1'b0);
        check({tag, "_hold"}, res(s), exp_res);
        check({tag, "_ready"}, rdy(s), 1'b1);
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [15:0] rb, re;

        rst_ct   = 1'b1;
        rst_nc   = 1'b1;
        start_ct = 1'b0;
        start_nc = 1'b0;
        base     = '0;
        expo     = '0;
        n_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_ct, 1'b1);
        check("rst_valid", valid_ct, 1'b0);
        check("rst_err", err_ct, 1'b0);
        check("rst_result", result_ct, 16'd0);
        check("rst_ready_nc", ready_nc, 1'b1);
        @(negedge clk);
        rst_ct = 1'b0;
        rst_nc = 1'b0;

        // Constant-time engine: latency is always 1+16+2*16*17 = 561.
        run(1'b0, 16'd4,     16'd13,     16'd497,   16'd445,  1'b0, 561, "ct_4_13");
        run(1'b0, 16'd65,    16'd17,     16'd3233,  16'd2790, 1'b0, 561, "rsa_enc");
        run(1'b0, 16'd2790,  16'd2753,   16'd3233,  16'd65,   1'b0, 561, "rsa_dec");
        run(1'b0, 16'd9,     16'd0,      16'd7,     16'd1,    1'b0, 561, "e0_n7");
        run(1'b0, 16'd9,     16'd0,      16'd1,     16'd0,    1'b0, 561, "e0_n1");
        run(1'b0, 16'd100,   16'd3,      16'd7,     16'd1,    1'b0, 561, "reduce");
        run(1'b0, 16'd0,     16'd5,      16'd11,    16'd0,    1'b0, 561, "base0");
        run(1'b0, 16'hFFFF,  16'hFFFF,   16'hFFFF,  16'd0,    1'b0, 561, "max");
        run(1'b0, 16'd5,     16'd3,      16'd0,     16'd0,    1'b1, 1,   "n0");

        // start held high through a whole operation, with the operand inputs
        // changed right after accept: neither may disturb the running job.
        issue(1'b0, 16'd65, 16'd17, 16'd3233, 1'b1);
        base = 16'd2;
        expo = 16'd1;
        n_in = 16'd5;
        wait_valid(1'b0, lat);
        check("held_lat", lat, 561);
        check("held_res", result_ct, 16'd2790);
        @(posedge clk);
        #1;
        check("held_idle_ready", ready_ct, 1'b1);
        @(posedge clk);
        #1;
        start_ct = 1'b0;
        check("held_clear_res", result_ct, 16'd0);
        check("held_busy", ready_ct, 1'b0);
        wait_valid(1'b0, lat);
        check("held2_lat", lat, 561);
        check("held2_res", result_ct, 16'd2);

        // Variable-time engine: 1+16+(16+3)*17 = 340.
        run(1'b1, 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 340, "nc_4_13");

        // Reset in the middle of the first SQUARE aborts without a valid.
        issue(1'b1, 16'd4, 16'd13, 16'd497, 1'b0);
        repeat (25) @(posedge clk);
        @(negedge clk);
        rst_nc = 1'b1;
        #1;
        check("abort_ready", ready_nc, 1'b1);
        check("abort_result", result_nc, 16'd0);
        check("abort_valid", valid_nc, 1'b0);
        @(negedge clk);
        rst_nc = 1'b0;
        pulses = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (valid_nc) pulses++;
        end
        check("abort_no_valid", pulses, 0);

        // Random operands against the reference model, N = 0xFFFD.
        for (int k = 0; k < 64; k++) begin
            rb = 16'($urandom_range(0, 65535));
            re = 16'($urandom_range(0, 65535));
            issue(1'b1, rb, re, 16'hFFFD, 1'b0);
            wait_valid(1'b1, lat);
            check("rnd_lat", lat, 1 + 16 + (16 + $countones(re)) * 17);
            check("rnd_res", result_nc, ref_modexp(rb, re, 16'hFFFD));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
